// File: rtl/mmm_mod_exp_pkg.sv
// mmm_mod_exp_pkg: shared state encoding, default multiplier geometry and counter sizing
package mmm_mod_exp_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam int MUL_LAT_DEF = 16;
  localparam int DIVW_DEF = 87;
  function automatic int cnt_w(input int lat);
    return $clog2(lat + 2);
  endfunction
endpackage

// File: rtl/mmm_mod_exp_if.sv
// mmm_mod_exp_if: request/response bus of the exponentiation engine, named from the engine's side
interface mmm_mod_exp_if #(
  parameter int WIDTH = 256,
  parameter int EW = 16
) ();
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_x;
  logic [EW-1:0]    i_e;
  logic [WIDTH-1:0] i_p;
  logic [WIDTH+2:0] i_m_b;
  logic [WIDTH-1:0] i_one;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_res;
  modport slave (
    input  i_valid, i_x, i_e, i_p, i_m_b, i_one, i_ready,
    output o_ready, o_valid, o_res
  );
  modport master (
    output i_valid, i_x, i_e, i_p, i_m_b, i_one, i_ready,
    input  o_ready, o_valid, o_res
  );
endinterface

// File: rtl/mmm_nlp_256b.sv
// mmm_nlp_256b: LAT-stage pipelined radix-2 Montgomery multiplier, o_r = a*b*2^-IDW mod p; i_m_b is the modulus at accumulator width
module mmm_nlp_256b
  import mmm_mod_exp_pkg::*;
#(
  parameter int ODW = 256,
  parameter int IDW = 256,
  parameter int DIVW = DIVW_DEF,
  parameter int LAT = MUL_LAT_DEF
) (
  input  logic           i_clk,
  input  logic [IDW-1:0] i_a,
  input  logic [IDW-1:0] i_b,
  input  logic [IDW+2:0] i_m_b,
  input  logic [IDW-1:0] i_p,
  output logic [ODW-1:0] o_r
);
  localparam int BPS = IDW / LAT;
  localparam int AW = ((IDW + 3 + DIVW - 1) / DIVW) * DIVW;
  function automatic logic [AW-1:0] step(input logic [AW-1:0] t, input logic [BPS-1:0] a,
                                         input logic [IDW-1:0] b, input logic [AW-1:0] m);
    logic [AW-1:0] v;
    v = t;
    for (int j = 0; j < BPS; j++) begin
      v = v + (a[j] ? AW'(b) : '0);
      v = (v + (v[0] ? m : '0)) >> 1;
    end
    return v;
  endfunction
  logic [AW-1:0]  w_m, w_p;
  logic [AW-1:0]  r_t [LAT];
  logic [IDW-1:0] r_a [LAT-1];
  logic [IDW-1:0] r_b [LAT-1];
  assign w_m = AW'(i_m_b);
  assign w_p = AW'(i_p);
  // partial accumulators: each stage consumes BPS bits of a
  always_ff @(posedge i_clk) begin
    r_t[0] <= step('0, i_a[BPS-1:0], i_b, w_m);
    for (int k = 1; k < LAT; k++) r_t[k] <= step(r_t[k-1], r_a[k-1][BPS-1:0], r_b[k-1], w_m);
  end
  // remaining multiplier bits and multiplicand travel alongside their accumulator
  always_ff @(posedge i_clk) begin
    r_a[0] <= i_a >> BPS;
    r_b[0] <= i_b;
    for (int k = 1; k < LAT - 1; k++) begin
      r_a[k] <= r_a[k-1] >> BPS;
      r_b[k] <= r_b[k-1];
    end
  end
  assign o_r = ODW'(r_t[LAT-1] >= w_p ? r_t[LAT-1] - w_p : r_t[LAT-1]);
endmodule

// File: rtl/mmm_mod_exp.sv
// mmm_mod_exp: right-to-left square-and-multiply x^e mod p over one shared Montgomery pipeline; MMM_MOD_EXP_EARLY_EXIT_EN stops after the top set exponent bit
module mmm_mod_exp
  import mmm_mod_exp_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int EW = 16,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIVW = DIVW_DEF
) (
  input logic          i_clk,
  input logic          i_rstn,
  mmm_mod_exp_if.slave bus
);
  localparam int CW = cnt_w(MUL_LAT);
  localparam int BW = $clog2(EW + 1);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bitcnt;
  logic [WIDTH-1:0] r_s, r_c, r_p, w_opb, w_prod;
  logic [WIDTH+2:0] r_mb;
  logic [EW-1:0]    r_e;
  logic             w_acc, w_sc, w_end, w_fin, w_skip;
  assign w_acc = r_state == ST_IDLE && bus.i_valid;
  assign w_sc  = r_state == ST_RUN && r_cnt == CW'(MUL_LAT);
  assign w_end = r_state == ST_RUN && r_cnt == CW'(MUL_LAT + 1);
`ifdef MMM_MOD_EXP_EARLY_EXIT_EN
  assign w_fin  = r_bitcnt == BW'(EW - 1) || r_e[EW-1:1] == '0;
  assign w_skip = bus.i_e == '0;
`else
  assign w_fin  = r_bitcnt == BW'(EW - 1);
  assign w_skip = 1'b0;
`endif
  // state register
  always_ff @(posedge i_clk) begin
    r_state <= !i_rstn ? ST_IDLE : w_next;
  end
  // next state: accept, finish after the last round, release on output handshake
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_skip ? ST_DONE : ST_RUN;
    if (w_end && w_fin) w_next = ST_DONE;
    if (r_state == ST_DONE && bus.i_ready) w_next = ST_IDLE;
  end
  // round and bit counters; clearing cnt on reset also orphans any in-flight products
  always_ff @(posedge i_clk) begin
    if (!i_rstn || w_acc) begin
      r_cnt <= '0;
      r_bitcnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cnt <= w_end ? '0 : r_cnt + 1'b1;
      r_bitcnt <= r_bitcnt + BW'(w_end);
    end
  end
  // C/S/E registers: latch on accept, C takes S*C when the bit is set, S takes S*S at round end
  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_s <= bus.i_x;
      r_c <= bus.i_one;
      r_e <= bus.i_e;
      r_p <= bus.i_p;
      r_mb <= bus.i_m_b;
    end else begin
      if (w_sc && r_e[0]) r_c <= w_prod;
      if (w_end) begin
        r_s <= w_prod;
        r_e <= r_e >> 1;
      end
    end
  end
  assign w_opb = r_cnt == '0 ? r_c : r_s;
  mmm_nlp_256b #(.ODW(WIDTH), .IDW(WIDTH), .DIVW(DIVW), .LAT(MUL_LAT)) u_mul (
    .i_clk (i_clk),
    .i_a   (r_s),
    .i_b   (w_opb),
    .i_m_b (r_mb),
    .i_p   (r_p),
    .o_r   (w_prod)
  );
  assign bus.o_ready = r_state == ST_IDLE;
  assign bus.o_valid = r_state == ST_DONE;
  assign bus.o_res   = r_state == ST_DONE ? r_c : '0;
endmodule

// File: tb/tb_mmm_mod_exp.sv
// tb_mmm_mod_exp: directed scoreboard bench; golden values come from plain modular arithmetic mapped into the Montgomery domain
module tb_mmm_mod_exp;
  localparam int LAT = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [255:0] gp, gone;
  logic [255:0] exp_q[$];
  int lat_q[$];
  int acc_q[$];

  mmm_mod_exp_if #(.WIDTH(256), .EW(16)) bus ();
  mmm_mod_exp dut (.i_clk(clk), .i_rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] mulmod(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] t;
    t = {256'b0, a} * {256'b0, b};
    t = t % {256'b0, gp};
    return t[255:0];
  endfunction

  function automatic logic [255:0] to_mont(input logic [255:0] v);
    logic [511:0] t;
    t = {v, 256'b0} % {256'b0, gp};
    return t[255:0];
  endfunction

  function automatic logic [255:0] powm(input logic [255:0] x, input logic [15:0] e);
    logic [255:0] r, b;
    r = 256'd1;
    b = x;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic int lat_of(input logic [15:0] e);
    int n;
    n = 16;
`ifdef MMM_MOD_EXP_EARLY_EXIT_EN
    n = 0;
    for (int i = 0; i < 16; i++) if (e[i]) n = i + 1;
`endif
    return n * (LAT + 2) + 1;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [255:0] xn, input logic [15:0] e);
    bus.i_valid = 1'b1;
    bus.i_x = to_mont(xn);
    bus.i_e = e;
    bus.i_p = gp;
    bus.i_m_b = {3'b0, gp};
    bus.i_one = gone;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge, i_valid still high
  task automatic issue(input logic [255:0] xn, input logic [15:0] e, output int acyc);
    drive(xn, e);
    acyc = -1;
    for (int i = 0; i < 2000 && acyc < 0; i++) begin
      if (bus.o_ready) begin
        acyc = cyc;
        exp_q.push_back(to_mont(powm(xn, e)));
        lat_q.push_back(lat_of(e));
        acc_q.push_back(acyc);
      end
      @(negedge clk);
    end
    if (acyc < 0) chk("accept_timeout", 256'd0, 256'd1);
  endtask

  // waits for o_valid, checks latency and result against the scoreboard head
  task automatic collect(input string tag, output logic [255:0] expv, output int vcyc);
    int a, l;
    bit seen;
    seen = 1'b0;
    vcyc = -1;
    expv = '0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (bus.o_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen || exp_q.size() == 0) begin
      chk({tag, "_timeout"}, 256'd0, 256'd1);
      return;
    end
    a = acc_q.pop_front();
    l = lat_q.pop_front();
    expv = exp_q.pop_front();
    vcyc = cyc;
    chk({tag, "_lat"}, 256'(vcyc - a), 256'(l));
    chk({tag, "_res"}, bus.o_res, expv);
  endtask

  task automatic run_one(input logic [255:0] xn, input logic [15:0] e, input string tag);
    int a, v;
    logic [255:0] ev;
    issue(xn, e, a);
    bus.i_valid = 1'b0;
    collect(tag, ev, v);
    @(negedge clk);
    chk({tag, "_idle"}, 256'(bus.o_ready), 256'd1);
  endtask

  initial begin
    int a, a2, v, r;
    logic [255:0] ev, x1, x2;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_x = '0;
    bus.i_e = '0;
    bus.i_p = '0;
    bus.i_m_b = '0;
    bus.i_one = '0;
    gp = rnd256();
    gp[255] = 1'b1;
    gp[0] = 1'b1;
    gone = to_mont(256'd1);
    repeat (3) @(negedge clk);
    chk("rst_ready", 256'(bus.o_ready), 256'd1);
    chk("rst_valid", 256'(bus.o_valid), 256'd0);
    chk("rst_res", bus.o_res, 256'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_one(rnd256() % gp, 16'h0005, "e0005");
    run_one(rnd256() % gp, 16'h0000, "e0000");
    run_one(rnd256() % gp, 16'h8001, "e8001");
    run_one(rnd256() % gp, 16'hFFFF, "eFFFF");
    run_one(256'd2, 16'h0009, "small");

    // backpressure: result held, second request ignored until release
    x1 = rnd256() % gp;
    x2 = rnd256() % gp;
    bus.i_ready = 1'b0;
    issue(x1, 16'h0003, a);
    bus.i_valid = 1'b0;
    collect("bp", ev, v);
    drive(x2, 16'h0007);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 256'(bus.o_valid), 256'd1);
      chk("bp_ready", 256'(bus.o_ready), 256'd0);
      chk("bp_hold", bus.o_res, ev);
    end
    bus.i_ready = 1'b1;
    r = cyc;
    issue(x2, 16'h0007, a2);
    chk("bp_accept", 256'(a2), 256'(r + 1));
    bus.i_valid = 1'b0;
    collect("bp2", ev, v);
    @(negedge clk);

    // reset at operation cycle 100 aborts, then a fresh request completes
    issue(rnd256() % gp, 16'hFFFF, a);
    bus.i_valid = 1'b0;
    repeat (99) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_ready", 256'(bus.o_ready), 256'd1);
    chk("abort_valid", 256'(bus.o_valid), 256'd0);
    rstn = 1'b1;
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    void'(acc_q.pop_front());
    @(negedge clk);
    run_one(rnd256() % gp, 16'h0003, "post_rst");

    // back-to-back with i_valid held high
    x1 = rnd256() % gp;
    x2 = rnd256() % gp;
    issue(x1, 16'hA5C3, a);
    drive(x2, 16'h0011);
    collect("b2b1", ev, v);
    @(negedge clk);
    issue(x2, 16'h0011, a2);
    chk("b2b_accept", 256'(a2), 256'(v + 1));
    bus.i_valid = 1'b0;
    collect("b2b2", ev, v);
    @(negedge clk);
    chk("final_idle", 256'(bus.o_ready), 256'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
